// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: scans NUM_DIGITS common-anode digits through one shared hex-to-7seg converter
module seven_seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    lz_blank,
    output logic [3:0]              hex_nibble,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);
    localparam int TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam int DW   = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] B_END = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] S_END = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] S_PRE = TW'((REFRESH_DIV >= 2) ? REFRESH_DIV - 2 : 0);
    localparam logic [DW-1:0] LAST  = DW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                  state;
    logic [TW-1:0]           timer;
    logic [DW-1:0]           digit_sel;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    upper_zero;

    assign hex_nibble = active[{digit_sel, 2'b00} +: 4];

    // true when the selected digit and every digit to its left are zero
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (i >= int'(digit_sel) && active[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end

    // scan FSM; frame_done is registered one cycle ahead so it lands on the last SHOW cycle of the final digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BLANK;
            timer      <= '0;
            digit_sel  <= '0;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (digit_sel == LAST) &&
                          ((state == BLANK && timer == B_END && REFRESH_DIV == 1) ||
                           (state == SHOW && timer == S_PRE && REFRESH_DIV > 1));
            if (state == BLANK) begin
                if (timer == B_END) begin
                    state <= SHOW;
                    timer <= '0;
                    an    <= ~(NUM_DIGITS'(1) << digit_sel);
                end else begin
                    timer <= timer + 1'b1;
                end
            end else if (timer == S_END) begin
                state     <= BLANK;
                timer     <= '0;
                an        <= '1;
                digit_sel <= (digit_sel == LAST) ? '0 : digit_sel + 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    // segment pin register with leading-zero override
    always_ff @(posedge clk or posedge reset) begin
        if (reset) seg_out <= 7'h7F;
        else       seg_out <= (lz_blank && digit_sel != '0 && upper_zero) ? 7'h7F : seg_in;
    end

    // double buffer: loads park in shadow, commit at the frame boundary; a boundary load bypasses shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (load) shadow <= value;
            if (frame_done) begin
                active  <= load ? value : (pending ? shadow : active);
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb_seven_seg_scan_controller: scenario tasks checked against a frame-position reference model
module tb_seven_seg_scan_controller;
    localparam int N = 4, RD = 4, BC = 2, P = BC + RD, FRAME = N * P;

    logic        clk = 1'b0, reset = 1'b0, load = 1'b0, lz_blank = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  hex_nibble, an;
    logic [6:0]  seg_in, seg_out;
    logic        frame_done, pending;

    int          checks = 0, errors = 0;
    int          k = 0;
    logic [15:0] disp = '0, shad = '0;
    logic        pend = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [6:0] conv(input logic [3:0] h);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[h];
    endfunction

    assign seg_in = conv(hex_nibble);

    seven_seg_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .lz_blank(lz_blank),
        .hex_nibble(hex_nibble), .seg_in(seg_in), .seg_out(seg_out), .an(an),
        .frame_done(frame_done), .pending(pending)
    );

    function automatic logic [3:0] exp_an(input int kk);
        return ((kk % P) < BC) ? 4'hF : ~(4'b0001 << (kk / P));
    endfunction

    function automatic logic [3:0] exp_nib(input int kk, input logic [15:0] v);
        return v[4*(kk/P) +: 4];
    endfunction

    function automatic logic [6:0] exp_seg(input int kk, input logic [15:0] v, input logic lz);
        int d = kk / P;
        return (lz && d > 0 && (v >> (4*d)) == 16'h0) ? 7'h7F : conv(v[4*d +: 4]);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (k == FRAME - 1) begin
                if (load) disp = value;
                else if (pend) disp = shad;
                pend = 1'b0;
            end else if (load) begin
                shad = value;
                pend = 1'b1;
            end
            k = (k + 1) % FRAME;
        end
        #1;
    endtask

    task automatic to_k(input int t);
        while (k != t) tick();
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({an, seg_out, frame_done, pending, hex_nibble} !== {4'hF, 7'h7F, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_outputs got an=%b seg=%b fd=%b pend=%b nib=%h exp an=1111 seg=1111111 fd=0 pend=0 nib=0",
                     an, seg_out, frame_done, pending, hex_nibble);
        end
        tick();
        tick();
        reset = 1'b0;
        k = 0; disp = '0; shad = '0; pend = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 2 * FRAME; i++) begin
            checks++;
            if ({an, frame_done, pending} !== {exp_an(k), k == FRAME - 1, pend}) begin
                errors++;
                $display("FAIL idle_ctrl k=%0d got an/fd/pend=%b exp %b", k, {an, frame_done, pending}, {exp_an(k), k == FRAME - 1, pend});
            end
            if (k % P >= BC) begin
                checks++;
                if ({seg_out, hex_nibble} !== {exp_seg(k, disp, lz_blank), exp_nib(k, disp)}) begin
                    errors++;
                    $display("FAIL idle_seg k=%0d got seg=%b nib=%h exp seg=%b nib=%h", k, seg_out, hex_nibble, exp_seg(k, disp, lz_blank), exp_nib(k, disp));
                end
            end
            tick();
        end
    endtask

    task automatic test_load_digits();
        for (int i = 0; i < 2 * FRAME; i++) begin
            checks++;
            if ({an, frame_done, pending} !== {exp_an(k), k == FRAME - 1, pend}) begin
                errors++;
                $display("FAIL load_ctrl k=%0d got an/fd/pend=%b exp %b", k, {an, frame_done, pending}, {exp_an(k), k == FRAME - 1, pend});
            end
            if (k % P >= BC) begin
                checks++;
                if ({seg_out, hex_nibble} !== {exp_seg(k, disp, lz_blank), exp_nib(k, disp)}) begin
                    errors++;
                    $display("FAIL load_seg k=%0d got seg=%b nib=%h exp seg=%b nib=%h", k, seg_out, hex_nibble, exp_seg(k, disp, lz_blank), exp_nib(k, disp));
                end
            end
            if (i == 3) begin load = 1'b1; value = 16'h12AF; end
            tick();
            load = 1'b0;
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] vals [2] = '{16'h0030, 16'h0000};
        for (int v = 0; v < 2; v++) begin
            to_k(FRAME - 1);
            lz_blank = 1'b1; load = 1'b1; value = vals[v];
            tick();
            load = 1'b0;
            for (int i = 0; i < FRAME; i++) begin
                checks++;
                if ({an, frame_done, pending} !== {exp_an(k), k == FRAME - 1, pend}) begin
                    errors++;
                    $display("FAIL lz_ctrl k=%0d got an/fd/pend=%b exp %b", k, {an, frame_done, pending}, {exp_an(k), k == FRAME - 1, pend});
                end
                if (k % P >= BC) begin
                    checks++;
                    if ({seg_out, hex_nibble} !== {exp_seg(k, disp, lz_blank), exp_nib(k, disp)}) begin
                        errors++;
                        $display("FAIL lz_seg k=%0d got seg=%b nib=%h exp seg=%b nib=%h", k, seg_out, hex_nibble, exp_seg(k, disp, lz_blank), exp_nib(k, disp));
                    end
                end
                tick();
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_tearing();
        to_k(8);
        for (int i = 0; i < 2 * FRAME; i++) begin
            checks++;
            if ({an, frame_done, pending} !== {exp_an(k), k == FRAME - 1, pend}) begin
                errors++;
                $display("FAIL tear_ctrl k=%0d got an/fd/pend=%b exp %b", k, {an, frame_done, pending}, {exp_an(k), k == FRAME - 1, pend});
            end
            if (k % P >= BC) begin
                checks++;
                if ({seg_out, hex_nibble} !== {exp_seg(k, disp, lz_blank), exp_nib(k, disp)}) begin
                    errors++;
                    $display("FAIL tear_seg k=%0d got seg=%b nib=%h exp seg=%b nib=%h", k, seg_out, hex_nibble, exp_seg(k, disp, lz_blank), exp_nib(k, disp));
                end
            end
            if (i == 0) begin load = 1'b1; value = 16'h1111; end
            if (i == 7) begin load = 1'b1; value = 16'h2222; end
            tick();
            load = 1'b0;
        end
    endtask

    task automatic test_bypass();
        to_k(20);
        for (int i = 0; i < FRAME + 4; i++) begin
            checks++;
            if ({an, frame_done, pending} !== {exp_an(k), k == FRAME - 1, pend}) begin
                errors++;
                $display("FAIL bypass_ctrl k=%0d got an/fd/pend=%b exp %b", k, {an, frame_done, pending}, {exp_an(k), k == FRAME - 1, pend});
            end
            if (k % P >= BC) begin
                checks++;
                if ({seg_out, hex_nibble} !== {exp_seg(k, disp, lz_blank), exp_nib(k, disp)}) begin
                    errors++;
                    $display("FAIL bypass_seg k=%0d got seg=%b nib=%h exp seg=%b nib=%h", k, seg_out, hex_nibble, exp_seg(k, disp, lz_blank), exp_nib(k, disp));
                end
            end
            if (i == 0) begin load = 1'b1; value = 16'h5555; end
            if (i == 3) begin load = 1'b1; value = 16'h9999; end
            tick();
            load = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        to_k(14);
        load = 1'b1; value = 16'h4321;
        tick();
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pending_before got %b exp 1", pending);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({an, seg_out, frame_done, pending, hex_nibble} !== {4'hF, 7'h7F, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL rmid_async got an=%b seg=%b fd=%b pend=%b nib=%h exp an=1111 seg=1111111 fd=0 pend=0 nib=0",
                     an, seg_out, frame_done, pending, hex_nibble);
        end
        k = 0; disp = '0; shad = '0; pend = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) begin
            checks++;
            if ({an, frame_done, pending} !== {exp_an(k), k == FRAME - 1, pend}) begin
                errors++;
                $display("FAIL rmid_ctrl k=%0d got an/fd/pend=%b exp %b", k, {an, frame_done, pending}, {exp_an(k), k == FRAME - 1, pend});
            end
            if (k % P >= BC) begin
                checks++;
                if ({seg_out, hex_nibble} !== {exp_seg(k, disp, lz_blank), exp_nib(k, disp)}) begin
                    errors++;
                    $display("FAIL rmid_seg k=%0d got seg=%b nib=%h exp seg=%b nib=%h", k, seg_out, hex_nibble, exp_seg(k, disp, lz_blank), exp_nib(k, disp));
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12 * FRAME; i++) begin
            checks++;
            if ({an, frame_done, pending} !== {exp_an(k), k == FRAME - 1, pend}) begin
                errors++;
                $display("FAIL rand_ctrl k=%0d got an/fd/pend=%b exp %b", k, {an, frame_done, pending}, {exp_an(k), k == FRAME - 1, pend});
            end
            if (k % P >= BC) begin
                checks++;
                if ({seg_out, hex_nibble} !== {exp_seg(k, disp, lz_blank), exp_nib(k, disp)}) begin
                    errors++;
                    $display("FAIL rand_seg k=%0d got seg=%b nib=%h exp seg=%b nib=%h", k, seg_out, hex_nibble, exp_seg(k, disp, lz_blank), exp_nib(k, disp));
                end
            end
            if (k % P == 0) lz_blank = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 7) == 0);
            value = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
            tick();
            load = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_digits();
        test_lz_blank();
        test_tearing();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
